bsg_fpu_class_to_float: RTL and testbench

//  Inverse of the FPU classifier. Takes a RISC-V fclass-style 10-bit class
//  one-hot and returns an IEEE-754 operand of exactly that class. Non-canonical

---
 rtl/bsg_fpu_class_to_float.sv | 100 ++++++++++
 tb/tb_bsg_fpu_class_to_float.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fpu_class_to_float.sv
// Turns a RISC-V fclass-style one-hot into an IEEE-754 operand of exactly that class.
// Free fields come from a 64-bit Galois LFSR that steps once per accepted request.
module bsg_fpu_class_to_float #(
  parameter int          e_p    = 11,
  parameter int          m_p    = 52,
  parameter logic [63:0] seed_p = 64'h1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [9:0]         class_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [e_p+m_p:0]   z_o,
  output logic               err_o,
  input  logic               yumi_i
);

  localparam logic [e_p-1:0] e_ones_lp   = {e_p{1'b1}};
  localparam logic [e_p-1:0] e_one_lp    = {{(e_p-1){1'b0}}, 1'b1};
  localparam logic [m_p-1:0] m_one_lp    = {{(m_p-1){1'b0}}, 1'b1};
  localparam logic [m_p-2:0] low_one_lp  = {{(m_p-2){1'b0}}, 1'b1};
  localparam logic [m_p-1:0] qnan_man_lp = {1'b1, {(m_p-1){1'b0}}};
  // Right-shifting Galois form of x^64+x^63+x^61+x^60+1.
  localparam logic [63:0]    lfsr_mask_lp = 64'hD800_0000_0000_0000;

  logic [63:0]      lfsr_r;
  logic [63:0]      lfsr_next;
  logic [e_p-1:0]   r_e;
  logic [m_p-1:0]   r_m;
  logic [m_p-2:0]   nan_low;
  logic             one_hot;
  logic             accept;
  logic             sign_n;
  logic [e_p-1:0]   exp_n;
  logic [m_p-1:0]   man_n;
  logic             err_n;

  // Handshake: input transfers when v_i & ready_o; output transfers when v_o & yumi_i.
  // A word leaving and a new word loading may happen in the same cycle.
  assign ready_o = ~v_o | yumi_i;
  assign accept  = v_i & ready_o;

  assign r_e     = lfsr_r[m_p +: e_p];
  assign r_m     = lfsr_r[m_p-1:0];
  assign nan_low = r_m[m_p-2:0];
  assign one_hot = (class_i != 10'd0) && ((class_i & (class_i - 10'd1)) == 10'd0);

  assign lfsr_next = (lfsr_r >> 1) ^ (lfsr_r[0] ? lfsr_mask_lp : 64'd0);

  always_comb begin
    sign_n = 1'b0;
    exp_n  = '0;
    man_n  = '0;
    err_n  = 1'b0;
    if (!one_hot) begin
      exp_n = e_ones_lp;
      man_n = qnan_man_lp;
      err_n = 1'b1;
    end else begin
      sign_n = |class_i[3:0];
      if (class_i[0] | class_i[7]) begin
        exp_n = e_ones_lp;
      end else if (class_i[1] | class_i[6]) begin
        // Clamp the exponent away from the zero/subnormal and inf/NaN encodings.
        if (r_e == '0)             exp_n = e_one_lp;
        else if (r_e == e_ones_lp) exp_n = e_ones_lp - e_one_lp;
        else                       exp_n = r_e;
        man_n = r_m;
      end else if (class_i[2] | class_i[5]) begin
        man_n = (r_m == '0) ? m_one_lp : r_m;
      end else if (class_i[8]) begin
        sign_n = lfsr_r[63];
        exp_n  = e_ones_lp;
        man_n  = {1'b0, ((nan_low == '0) ? low_one_lp : nan_low)};
      end else if (class_i[9]) begin
        sign_n = lfsr_r[63];
        exp_n  = e_ones_lp;
        man_n  = {1'b1, nan_low};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_o    <= 1'b0;
      z_o    <= '0;
      err_o  <= 1'b0;
      lfsr_r <= seed_p;
    end else if (accept) begin
      v_o    <= 1'b1;
      z_o    <= {sign_n, exp_n, man_n};
      err_o  <= err_n;
      lfsr_r <= lfsr_next;
    end else if (yumi_i) begin
      v_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bsg_fpu_class_to_float.sv
// Bench for bsg_fpu_class_to_float (e_p=11, m_p=52): directed vectors, backpressure,
// random round trip through an independent classifier, and reset replay.
module tb_bsg_fpu_class_to_float;

  localparam logic [63:0] seed_lp = 64'h1;

  logic        clk;
  logic        reset_i;
  logic        v_i;
  logic [9:0]  class_i;
  logic        ready_o;
  logic        v_o;
  logic [63:0] z_o;
  logic        err_o;
  logic        yumi_i;

  int total = 0;
  int bad   = 0;

  logic [64:0] exp_q[$];
  logic [9:0]  cls_q[$];
  logic [63:0] cap_q[$];
  logic [63:0] run1_q[$];
  logic [63:0] lfsr_m;
  bit          capture = 0;

  bsg_fpu_class_to_float #(.e_p(11), .m_p(52), .seed_p(seed_lp)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .class_i (class_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .z_o     (z_o),
    .err_o   (err_o),
    .yumi_i  (yumi_i)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    int          taps[4] = '{64, 63, 61, 60};
    logic [63:0] mask = 64'd0;
    foreach (taps[i]) mask[taps[i]-1] = 1'b1;
    return l[0] ? ((l >> 1) ^ mask) : (l >> 1);
  endfunction

  // Reference model: operand of the requested class from the spec's field rules.
  function automatic logic [64:0] gen_word(input logic [9:0] cls, input logic [63:0] l);
    logic [63:0] re, rm, lo, ex, mn;
    logic        s;
    int          idx = 0;
    if ($countones(cls) != 1) return {1'b1, 64'h7FF8_0000_0000_0000};
    for (int i = 0; i < 10; i++) if (cls[i]) idx = i;
    re = (l >> 52) % 64'd2048;
    rm = l % (64'd1 << 52);
    lo = rm % (64'd1 << 51);
    s  = (idx <= 3);
    ex = 0;
    mn = 0;
    case (idx)
      0, 7: ex = 2047;
      1, 6: begin
        ex = (re == 0) ? 64'd1 : ((re == 2047) ? 64'd2046 : re);
        mn = rm;
      end
      2, 5: mn = (rm == 0) ? 64'd1 : rm;
      8: begin s = l[63]; ex = 2047; mn = (lo == 0) ? 64'd1 : lo; end
      9: begin s = l[63]; ex = 2047; mn = (64'd1 << 51) + lo; end
      default: ;
    endcase
    return {1'b0, s, ex[10:0], mn[51:0]};
  endfunction

  function automatic logic [9:0] classify(input logic [63:0] z);
    logic        s = z[63];
    logic [10:0] e = z[62:52];
    logic [51:0] m = z[51:0];
    int          c;
    if (e == 11'h7FF)     c = (m == 0) ? (s ? 0 : 7) : (m[51] ? 9 : 8);
    else if (e == 11'h0)  c = (m == 0) ? (s ? 3 : 4) : (s ? 2 : 5);
    else                  c = s ? 1 : 6;
    return 10'd1 << c;
  endfunction

  // driver + scoreboard for one clock cycle
  task automatic drive_cycle(input logic v, input logic [9:0] cls, input logic y);
    logic [64:0] w;
    logic [9:0]  c;
    logic        mv;
    @(negedge clk);
    mv      = (exp_q.size() != 0);
    v_i     = v;
    class_i = cls;
    yumi_i  = y & mv;
    #1;
    check("v_o", 65'(v_o), 65'(mv));
    check("ready_o", 65'(ready_o), 65'(!mv || yumi_i));
    if (yumi_i) begin
      w = exp_q.pop_front();
      c = cls_q.pop_front();
      check("word", {err_o, z_o}, w);
      if (!w[64]) check("round_trip", 65'(classify(z_o)), 65'(c));
      if (capture) cap_q.push_back(z_o);
    end
    if (v && (!mv || yumi_i)) begin
      exp_q.push_back(gen_word(cls, lfsr_m));
      cls_q.push_back(cls);
      lfsr_m = lfsr_step(lfsr_m);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    class_i = 10'd0;
    repeat (cycles) @(negedge clk);
    #1;
    check("rst_v_o", 65'(v_o), 65'(0));
    check("rst_z_o", 65'(z_o), 65'(0));
    check("rst_err_o", 65'(err_o), 65'(0));
    reset_i = 1'b0;
    exp_q.delete();
    cls_q.delete();
    lfsr_m = seed_lp;
    #1;
    check("rst_ready_o", 65'(ready_o), 65'(1));
  endtask

  task automatic replay_run();
    logic [9:0] seq[8] = '{10'h002, 10'h004, 10'h100, 10'h200,
                           10'h040, 10'h020, 10'h100, 10'h002};
    capture = 1;
    foreach (seq[i]) drive_cycle(1'b1, seq[i], 1'b1);
    drive_cycle(1'b0, 10'd0, 1'b1);
    capture = 0;
  endtask

  task automatic directed(input logic [9:0] cls, input logic [63:0] z, input logic e, input string tag);
    drive_cycle(1'b1, cls, 1'b1);
    drive_cycle(1'b0, 10'd0, 1'b0);
    check(tag, {e, z}, {err_o, z_o});
  endtask

  initial begin
    logic [63:0] held;
    logic [9:0]  cls;
    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    class_i = 10'd0;
    lfsr_m  = seed_lp;
    do_reset(3);

    replay_run();
    run1_q = cap_q;
    cap_q.delete();

    directed(10'h001, 64'hFFF0_0000_0000_0000, 1'b0, "fix_neg_inf");
    directed(10'h008, 64'h8000_0000_0000_0000, 1'b0, "fix_neg_zero");
    directed(10'h010, 64'h0000_0000_0000_0000, 1'b0, "fix_pos_zero");
    directed(10'h080, 64'h7FF0_0000_0000_0000, 1'b0, "fix_pos_inf");
    directed(10'h000, 64'h7FF8_0000_0000_0000, 1'b1, "bad_none");
    directed(10'h003, 64'h7FF8_0000_0000_0000, 1'b1, "bad_two");

    // backpressure: word parked, requests keep coming, nothing moves
    drive_cycle(1'b1, 10'h040, 1'b1);
    held = 64'd0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 10'd1 << $urandom_range(0, 9), 1'b0);
      if (i == 0) held = z_o;
      else check("bp_hold", 65'(z_o), 65'(held));
    end
    drive_cycle(1'b1, 10'h200, 1'b1);
    check("bp_release_ready", 65'(ready_o), 65'(1));

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 19) == 0) cls = 10'($urandom_range(0, 1023));
      else                            cls = 10'd1 << $urandom_range(0, 9);
      drive_cycle($urandom_range(0, 3) != 0, cls, $urandom_range(0, 1) != 0);
    end

    // reset while holding a word, then expect the identical sequence again
    drive_cycle(1'b1, 10'h002, 1'b0);
    drive_cycle(1'b0, 10'd0, 1'b0);
    check("pre_reset_v_o", 65'(v_o), 65'(1));
    do_reset(1);
    replay_run();
    check("replay_len", 65'(cap_q.size()), 65'(run1_q.size()));
    for (int i = 0; i < cap_q.size() && i < run1_q.size(); i++)
      check("replay_word", 65'(cap_q[i]), 65'(run1_q[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
